// File: rtl/iir_pkg.sv
// Shared constants, FSM state type and the rounding/saturation helper for the
// second-order-section IIR engine.
package iir_pkg;

    localparam logic [2:0] K_B0 = 3'd0;
    localparam logic [2:0] K_B1 = 3'd1;
    localparam logic [2:0] K_B2 = 3'd2;
    localparam logic [2:0] K_A1 = 3'd3;
    localparam logic [2:0] K_A2 = 3'd4;
    localparam int         NK   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Round half-up at bit frac, shift down, then clamp to a signed dw-bit range.
    // Works on a 64-bit container so it serves any accumulator up to that width.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int dw,
                                                     input int frac);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient banks. Writes land in the shadow bank at any time;
// a swap copies the shadow bank and the requested section count into the active set.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int CW   = 16,
    parameter int NSEC = 4,
    parameter int AW   = $clog2(NSEC) + 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    coef_we,
    input  logic [AW-1:0]                           coef_addr,
    input  logic signed [CW-1:0]                    coef_data,
    input  logic [$clog2(NSEC+1)-1:0]               nsec_cfg,
    input  logic                                    swap_apply,
    input  logic [((NSEC > 1) ? $clog2(NSEC) : 1)-1:0] rd_sec,
    input  logic [2:0]                              rd_k,
    output logic signed [CW-1:0]                    coef_rd,
    output logic [$clog2(NSEC+1)-1:0]               nsec_act,
    output logic [$clog2(NSEC+1)-1:0]               nsec_eff
);

    localparam int NW = $clog2(NSEC + 1);

    logic signed [CW-1:0] shadow_q [NSEC][NK];
    logic signed [CW-1:0] shadow_d [NSEC][NK];
    logic signed [CW-1:0] active_q [NSEC][NK];
    logic signed [CW-1:0] active_d [NSEC][NK];
    logic [NW-1:0]        nsec_q;
    logic [NW-1:0]        nsec_d;
    logic [NW-1:0]        nsec_clamped;

    assign nsec_clamped = (int'(nsec_cfg) > NSEC) ? NW'(NSEC) : nsec_cfg;
    assign nsec_act     = nsec_q;
    // The FSM needs the post-swap count in the same IDLE cycle the swap lands.
    assign nsec_eff     = swap_apply ? nsec_clamped : nsec_q;
    assign coef_rd      = (rd_k <= K_A2) ? active_q[rd_sec][rd_k] : '0;

    // Shadow write port; k values 5..7 and out-of-range sections are dropped.
    always_comb begin
        shadow_d = shadow_q;
        if (coef_we && (int'(coef_addr[AW-1:3]) < NSEC) && (coef_addr[2:0] <= K_A2)) begin
            shadow_d[coef_addr[AW-1:3]][coef_addr[2:0]] = coef_data;
        end
    end

    // Active set only changes on an applied swap.
    always_comb begin
        active_d = active_q;
        nsec_d   = nsec_q;
        if (swap_apply) begin
            active_d = shadow_q;
            nsec_d   = nsec_clamped;
        end
    end

    // Bank registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            nsec_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            nsec_q   <= nsec_d;
        end
    end

endmodule

// File: rtl/iir_sos_engine.sv
// Cascade of Direct-Form-I biquads sharing one multiplier, with a valid/ready
// sample handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a sample; pending swap/clear are applied here
// MAC   | one product per cycle for section sec_q, k = b0,b1,b2,a1,a2
// WB    | round/saturate, shift the section's delay line, next section
// OUT   | y_out/y_valid presented for one cycle
module iir_sos_engine
    import iir_pkg::*;
#(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 11,
    parameter int NSEC = 4,
    parameter int AW   = $clog2(NSEC) + 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DW-1:0]         x_in,
    input  logic                         x_valid,
    output logic                         x_ready,
    output logic signed [DW-1:0]         y_out,
    output logic                         y_valid,
    input  logic                         coef_we,
    input  logic [AW-1:0]                coef_addr,
    input  logic signed [CW-1:0]         coef_data,
    input  logic [$clog2(NSEC+1)-1:0]    nsec_cfg,
    input  logic                         coef_swap,
    input  logic                         state_clr,
    output logic                         busy
);

    localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int NW  = $clog2(NSEC + 1);
    localparam int PW  = DW + CW;
    localparam int ACW = DW + CW + 4;

    state_e               state_q, state_d;
    logic [SW-1:0]        sec_q, sec_d;
    logic [2:0]           k_q, k_d;
    logic signed [ACW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] sin_q, sin_d;
    logic signed [DW-1:0] x1_q [NSEC];
    logic signed [DW-1:0] x1_d [NSEC];
    logic signed [DW-1:0] x2_q [NSEC];
    logic signed [DW-1:0] x2_d [NSEC];
    logic signed [DW-1:0] y1_q [NSEC];
    logic signed [DW-1:0] y1_d [NSEC];
    logic signed [DW-1:0] y2_q [NSEC];
    logic signed [DW-1:0] y2_d [NSEC];
    logic signed [DW-1:0] y_out_q, y_out_d;
    logic                 y_valid_q, y_valid_d;
    logic                 x_ready_q, x_ready_d;
    logic                 busy_q, busy_d;
    logic                 swap_pend_q, swap_pend_d;
    logic                 clr_pend_q, clr_pend_d;

    logic                 swap_apply, clr_apply, accept;
    logic signed [CW-1:0] coef_rd;
    logic [NW-1:0]        nsec_act, nsec_eff;
    logic signed [DW-1:0] mul_x;
    logic signed [PW-1:0] prod;
    logic signed [ACW-1:0] prod_ext;
    logic signed [DW-1:0] y_s;

    assign swap_apply = (state_q == IDLE) && (coef_swap || swap_pend_q);
    assign clr_apply  = (state_q == IDLE) && (state_clr || clr_pend_q);
    assign accept     = x_valid && x_ready_q;

    assign x_ready = x_ready_q;
    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;

    iir_coef_bank #(.CW(CW), .NSEC(NSEC), .AW(AW)) u_bank (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .nsec_cfg   (nsec_cfg),
        .swap_apply (swap_apply),
        .rd_sec     (sec_q),
        .rd_k       (k_q),
        .coef_rd    (coef_rd),
        .nsec_act   (nsec_act),
        .nsec_eff   (nsec_eff)
    );

    // Shared multiplier operand: the sample tap matching the coefficient index.
    always_comb begin
        mul_x = sin_q;
        unique case (k_q)
            K_B0:    mul_x = sin_q;
            K_B1:    mul_x = x1_q[sec_q];
            K_B2:    mul_x = x2_q[sec_q];
            K_A1:    mul_x = y1_q[sec_q];
            K_A2:    mul_x = y2_q[sec_q];
            default: mul_x = sin_q;
        endcase
    end

    assign prod     = PW'(mul_x) * PW'(coef_rd);
    assign prod_ext = ACW'(prod);
    assign y_s      = DW'(sat_round(64'(acc_q), DW, FRAC));

    // Next-state, datapath and deferred swap/clear bookkeeping.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        k_d         = k_q;
        acc_d       = acc_q;
        sin_d       = sin_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        y_out_d     = y_out_q;
        y_valid_d   = 1'b0;
        swap_pend_d = !swap_apply && (swap_pend_q || coef_swap);
        clr_pend_d  = !clr_apply && (clr_pend_q || state_clr);

        if (clr_apply) begin
            x1_d = '{default: '0};
            x2_d = '{default: '0};
            y1_d = '{default: '0};
            y2_d = '{default: '0};
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (nsec_eff == '0) begin
                        y_out_d   = x_in;
                        y_valid_d = 1'b1;
                        state_d   = OUT;
                    end else begin
                        sin_d   = x_in;
                        sec_d   = '0;
                        k_d     = K_B0;
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                if (k_q == K_B0) begin
                    acc_d = prod_ext;
                end else if (k_q >= K_A1) begin
                    acc_d = acc_q - prod_ext;
                end else begin
                    acc_d = acc_q + prod_ext;
                end
                if (k_q == K_A2) begin
                    state_d = WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            WB: begin
                x1_d[sec_q] = sin_q;
                x2_d[sec_q] = x1_q[sec_q];
                y1_d[sec_q] = y_s;
                y2_d[sec_q] = y1_q[sec_q];
                sin_d       = y_s;
                if (int'(sec_q) + 1 < int'(nsec_act)) begin
                    sec_d   = sec_q + SW'(1);
                    k_d     = K_B0;
                    state_d = MAC;
                end else begin
                    y_out_d   = y_s;
                    y_valid_d = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    // State, datapath and delay-line registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sec_q       <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            sin_q       <= '0;
            x1_q        <= '{default: '0};
            x2_q        <= '{default: '0};
            y1_q        <= '{default: '0};
            y2_q        <= '{default: '0};
            y_out_q     <= '0;
            y_valid_q   <= 1'b0;
            x_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            swap_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            sin_q       <= sin_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            y_out_q     <= y_out_d;
            y_valid_q   <= y_valid_d;
            x_ready_q   <= x_ready_d;
            busy_q      <= busy_d;
            swap_pend_q <= swap_pend_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

endmodule

// File: tb/tb_iir_sos_engine.sv
// Scoreboard bench for iir_sos_engine: the driver computes each expected output
// with a plain-arithmetic biquad cascade model and queues it with the cycle it
// should appear on; a monitor pops and compares whenever y_valid is seen.
module tb_iir_sos_engine;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FRAC = 11;
    localparam int NSEC = 4;
    localparam int AW   = $clog2(NSEC) + 3;
    localparam int NW   = $clog2(NSEC + 1);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic signed [DW-1:0] x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [DW-1:0] y_out;
    logic                 y_valid;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic [NW-1:0]        nsec_cfg;
    logic                 coef_swap;
    logic                 state_clr;
    logic                 busy;

    always #5 clk = ~clk;

    iir_sos_engine #(.DW(DW), .CW(CW), .FRAC(FRAC), .NSEC(NSEC), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .nsec_cfg  (nsec_cfg),
        .coef_swap (coef_swap),
        .state_clr (state_clr),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int y;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state: coefficient banks, section count and delay lines.
    int m_sh  [NSEC][5];
    int m_act [NSEC][5];
    int m_n;
    int m_x1 [NSEC];
    int m_x2 [NSEC];
    int m_y1 [NSEC];
    int m_y2 [NSEC];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear_delays();
        for (int s = 0; s < NSEC; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NSEC; s++)
            for (int k = 0; k < 5; k++) begin
                m_sh[s][k]  = 0;
                m_act[s][k] = 0;
            end
        m_n = 0;
        model_clear_delays();
    endfunction

    function automatic void model_swap(input int cfg);
        m_act = m_sh;
        m_n   = (cfg > NSEC) ? NSEC : cfg;
    endfunction

    function automatic int sat_rnd(input longint acc);
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        r  = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return int'(r);
    endfunction

    // y[n] = b0 x[n] + b1 x[n-1] + b2 x[n-2] - a1 y[n-1] - a2 y[n-2], per section.
    function automatic int model_sample(input int x);
        int     s_in;
        int     ys;
        longint acc;
        s_in = x;
        for (int s = 0; s < m_n; s++) begin
            acc = longint'(m_act[s][0]) * s_in
                + longint'(m_act[s][1]) * m_x1[s]
                + longint'(m_act[s][2]) * m_x2[s]
                - longint'(m_act[s][3]) * m_y1[s]
                - longint'(m_act[s][4]) * m_y2[s];
            ys      = sat_rnd(acc);
            m_x2[s] = m_x1[s];
            m_x1[s] = s_in;
            m_y2[s] = m_y1[s];
            m_y1[s] = ys;
            s_in    = ys;
        end
        return s_in;
    endfunction

    task automatic wcoef(input int sec, input int k, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(sec * 8 + k);
        coef_data = CW'(val);
        if (sec < NSEC && k < 5) m_sh[sec][k] = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic swap(input int cfg);
        @(negedge clk);
        coef_swap = 1'b1;
        nsec_cfg  = NW'(cfg);
        model_swap(cfg);
        @(negedge clk);
        coef_swap = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        state_clr = 1'b1;
        model_clear_delays();
        @(negedge clk);
        state_clr = 1'b0;
    endtask

    // Present one sample (optionally with a swap in the same cycle) and queue its result.
    task automatic send(input logic [DW-1:0] x, input bit sw = 1'b0, input int cfg = 0);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!x_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!x_ready) begin
            chk("x_ready_wait", x_ready, 1);
            return;
        end
        x_in    = x;
        x_valid = 1'b1;
        if (sw) begin
            coef_swap = 1'b1;
            nsec_cfg  = NW'(cfg);
            model_swap(cfg);
        end
        e.at = cyc + 6 * m_n + 1;
        e.y  = model_sample(int'($signed(x)));
        sb.push_back(e);
        @(negedge clk);
        x_valid   = 1'b0;
        coef_swap = 1'b0;
        chk("x_ready_drop", x_ready, 0);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_outstanding", sb.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: every y_valid must match the oldest queued expectation, on time.
    always @(negedge clk) begin
        if (reset && y_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_y_valid: got y_out=%0d, expected no output", y_out);
            end else begin
                mon_e = sb.pop_front();
                chk("y_out", y_out, mon_e.y);
                chk("y_valid_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        x_in = '0; x_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        nsec_cfg = '0; coef_swap = 1'b0; state_clr = 1'b0;
        model_reset();

        // Reset values, then release.
        repeat (2) @(negedge clk);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("x_ready_after_release", x_ready, 1);

        // Bypass with nsec=0.
        send(16'h1234);
        drain();

        // One section, unity b0: impulse response.
        wcoef(0, 0, 'h0800);
        swap(1);
        send(16'h0100); send(16'h0000); send(16'h0000);
        drain();

        // Recursive section y = x + 0.5*y1.
        wcoef(0, 3, -1024);
        clr();
        swap(1);
        send(16'h0400); send(16'h0000); send(16'h0000); send(16'h0000);
        drain();

        // Per-section saturation with b0 = 2.0.
        wcoef(0, 3, 0);
        wcoef(0, 0, 'h1000);
        swap(1);
        send(16'h7000); send(16'h9000);
        drain();

        // Two sections of 0.5, with a coefficient update and swap while busy.
        wcoef(0, 0, 'h0400);
        wcoef(1, 0, 'h0400);
        swap(2);
        send(16'h0800);
        wcoef(0, 0, 'h0800);
        wcoef(1, 0, 'h0800);
        chk("busy_at_mid_swap", busy, 1);
        swap(2);
        drain();
        send(16'h0800);
        drain();

        // Swap to nsec=0 in the same cycle as a sample: that sample bypasses.
        send(16'h0555, 1'b1, 0);
        drain();

        // Oversized nsec_cfg clamps to NSEC.
        wcoef(2, 0, 'h0800);
        wcoef(3, 0, 'h0800);
        swap(7);
        send(16'h0300);
        drain();

        // Reset in the middle of a sample: no output, everything cleared.
        swap(1);
        send(16'h0111);
        drain();
        send(16'h0222);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        model_reset();
        @(negedge clk);
        chk("midrst_y_valid", y_valid, 0);
        chk("midrst_y_out", y_out, 0);
        chk("midrst_x_ready", x_ready, 0);
        chk("midrst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("x_ready_after_midrst", x_ready, 1);
        send(16'h1234);
        drain();
        wcoef(0, 0, 'h0800);
        wcoef(0, 3, -1024);
        swap(1);
        send(16'h0400); send(16'h0000); send(16'h0000);
        drain();

        // Randomized configurations and samples.
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < NSEC; s++) begin
                for (int k = 0; k < 3; k++) wcoef(s, k, int'($urandom_range(0, 3072)) - 1536);
                for (int k = 3; k < 5; k++) wcoef(s, k, int'($urandom_range(0, 1536)) - 768);
                wcoef(s, 5 + int'($urandom_range(0, 2)), int'($urandom_range(0, 65535)) - 32768);
            end
            swap(int'($urandom_range(0, 7)));
            for (int n = 0; n < 10; n++) begin
                if ($urandom_range(0, 7) == 0) clr();
                send(DW'($urandom));
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_sos_engine.md
Name: iir_sos_engine

Overview:
- Parametrised successor to the fixed-port programmable IIR filter.
- Cascade of up to NSEC Direct-Form-I second-order sections (biquads). Coefficients are written through an addressed port instead of wide parallel buses.
- One shared multiplier, time-multiplexed; a valid/ready sample handshake replaces free-running per-clock sampling.
- Sits between the SDR sample source and the downstream decimator/output stage.

Parameters:
- DW, 16, sample width (signed two's complement).
- CW, 16, coefficient width (signed).
- FRAC, 11, coefficient fractional bits (1.0 = 0x0800).
- NSEC, 4, maximum number of biquad sections (filter order up to 2*NSEC).
- AW, $clog2(NSEC)+3, coefficient address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- x_in  in  DW  input sample.
- x_valid  in  1  input sample valid.
- x_ready  out  1  engine can accept a sample.
- y_out  out  DW  filtered sample; held until the next result.
- y_valid  out  1  one-cycle pulse when y_out updates.
- coef_we  in  1  write enable, shadow coefficient bank.
- coef_addr  in  AW  address = section*8 + k, with k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; k 5..7 ignored.
- coef_data  in  CW  coefficient value.
- nsec_cfg  in  $clog2(NSEC+1)  requested section count, latched on swap.
- coef_swap  in  1  pulse: copy shadow bank and nsec_cfg into the active set.
- state_clr  in  1  pulse: zero all section delay lines.
- busy  out  1  a sample is in flight.

Behaviour:
- Reset (async, reset=0):
  - FSM goes to IDLE.
  - x_ready=0, y_out=0, y_valid=0, busy=0.
  - Shadow and active banks are zero; delay lines are zero; active nsec=0 (bypass).
  - x_ready rises on the first clk after reset is released.
- Reset mid-operation aborts the sample. No y_valid is issued for it.
- Handshake:
  - A sample is accepted when x_valid && x_ready.
  - x_ready=1 only in IDLE. It is registered, so it drops the cycle after acceptance.
- Bypass (active nsec=0): y_out<=x_in and y_valid pulses 1 cycle after acceptance. Delay lines are untouched.
- FSM states and transitions:
  - IDLE -> MAC on accept.
  - MAC: k=0..4, one product per cycle, acc += b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2. After k=4 -> WB.
  - WB (one cycle):
    - y_s = sat(round(acc)).
    - Shift x1<=x, x2<=x1, y1<=y_s, y2<=y1.
    - Section input for s+1 = y_s.
    - If s < nsec-1, go back to MAC with s+1; otherwise go to OUT.
  - OUT: y_out<=y_last, y_valid=1, then IDLE.
- Latency: accept to y_valid = 6*nsec + 1 cycles. Throughput is one sample per 6*nsec + 2 cycles.
- Arithmetic:
  - Products are DW+CW bits; the accumulator is DW+CW+4 bits.
  - Rounding: round-half-up by adding 2^(FRAC-1), then arithmetic shift right by FRAC.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1] per section, not just at the final output.
- Coefficient writes:
  - Go to the shadow bank at any time, including while busy.
  - Addresses with section >= NSEC are ignored.
- coef_swap:
  - Applied only in IDLE; a pulse while busy is held pending until IDLE.
  - Swap and x_valid in the same IDLE cycle: the swap applies first, and that sample uses the new set.
  - nsec_cfg > NSEC clamps to NSEC.
- state_clr: same deferral rules as swap. If both are pending, both apply in the same cycle.
- busy=1 from the cycle after accept until the OUT cycle inclusive.

Decomposition:
- Package iir_pkg:
  - Coefficient index constants K_B0..K_A2.
  - State enum IDLE/MAC/WB/OUT.
  - Function sat_round(acc) for rounding and saturation.
- Sub-module iir_coef_bank:
  - Shadow plus active register banks, with the write port and swap logic.
  - Provides a read mux by (section, k).
- Top module iir_sos_engine holds the FSM, MAC datapath and delay-line registers.

Test Plan:
- Reset then nsec=0: x_in=0x1234 -> y_out=0x1234, y_valid 1 cycle after accept; x_ready=0 during reset, 1 the first cycle after release.
- 1 section, b0=0x0800, others 0, swap: impulse 0x0100 then zeros -> y=0x0100, 0, 0; y_valid exactly 7 cycles after each accept.
- 1 section, b0=0x0800, a1=0xFC00 (-0.5): impulse 0x0400 -> y=0x0400, 0x0200, 0x0100, 0x0080 (y = x + 0.5*y1).
- Saturation, b0=0x1000 (2.0): x=0x7000 -> 0x7FFF; x=0x9000 -> 0x8000.
- 2 sections, each b0=0x0400: x=0x0800 -> y=0x0200, latency 13. Write b0=0x0800 for both sections plus pulse coef_swap mid-sample -> current sample still 0x0200, next x=0x0800 -> 0x0800.
- Assert reset during MAC of sample 2 -> no y_valid, y_out=0; after release nsec=0 bypass, and delay lines are verified zero by a fresh impulse giving the 1-section impulse response once reconfigured.
